input_stream_reader_data_fifo: RTL and testbench

- Input-side counterpart of the output stream writer's data FIFO. It sits between the host/card DMA read stream and the operator pipeline.
- It accepts a transfer descriptor (byte length), trims host beats to exactly that many bytes, and asserts tlast on the beat holding the final byte.
- It discards host padding beats after that, and emits a single zero-keep last beat for zero-length transfers so downstream always sees an end marker.
- Output is buffered in an axi_fifo followed by axi_ready_de_coupler.

---
 rtl/libstf_stream_pkg.sv | 31 +++
 rtl/axi_fifo.sv | 71 +++++++
 rtl/axi_ready_de_coupler.sv | 57 +++++
 rtl/input_stream_reader_trimmer.sv | 166 ++++++++++++++++
 rtl/input_stream_reader_data_fifo.sv | 102 ++++++++++
 tb/tb_input_stream_reader_data_fifo.sv | 332 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/libstf_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : libstf_stream_pkg
// Purpose  : Shared constants, reader FSM state type and keep-mask helper for
//            the input stream reader data path.
// Revision : 1.0 - initial release
// ============================================================================
package libstf_stream_pkg;

    localparam int BYTES_PER_BEAT = 64;
    localparam int KEEP_IDX_BITS  = $clog2(BYTES_PER_BEAT) + 1;

    localparam logic [BYTES_PER_BEAT:0] c_MASK_ONE = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        ZERO   = 2'd2,
        DRAIN  = 2'd3
    } reader_state_t;

    // Low-ones byte mask; count == BYTES_PER_BEAT yields all ones because the
    // shift is done one bit wider than the mask.
    function automatic logic [BYTES_PER_BEAT-1:0] keep_mask(input logic [KEEP_IDX_BITS-1:0] count);
        logic [BYTES_PER_BEAT:0] ones;
        ones = (c_MASK_ONE << count) - c_MASK_ONE;
        return ones[BYTES_PER_BEAT-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axi_fifo
// Purpose  : Synchronous first-word-fall-through stream FIFO with occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module axi_fifo #(
    parameter int WIDTH = 577,
    parameter int DEPTH = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       i_s_tdata,
    input  logic                   i_s_tvalid,
    output logic                   o_s_tready,
    output logic [WIDTH-1:0]       o_m_tdata,
    output logic                   o_m_tvalid,
    input  logic                   i_m_tready,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] c_LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] c_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0] c_ONE      = CW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_s_tready = (r_count != c_DEPTH);
    assign o_m_tvalid = (r_count != '0);
    assign o_m_tdata  = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign w_wr       = i_s_tvalid & o_s_tready;
    assign w_rd       = o_m_tvalid & i_m_tready;

    // Storage array; contents need no reset since occupancy gates the reads.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_s_tdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_ready_de_coupler.sv
`default_nettype none
// ============================================================================
// Module   : axi_ready_de_coupler
// Purpose  : Two-entry skid buffer; registers both valid/data and the ready
//            path so downstream tready never reaches upstream combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module axi_ready_de_coupler #(
    parameter int WIDTH = 577
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_s_tdata,
    input  logic             i_s_tvalid,
    output logic             o_s_tready,
    output logic [WIDTH-1:0] o_m_tdata,
    output logic             o_m_tvalid,
    input  logic             i_m_tready
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_valid;
    logic             w_out_free;

    assign o_s_tready = ~r_skid_valid;
    assign o_m_tdata  = r_out_data;
    assign o_m_tvalid = r_out_valid;
    assign w_out_free = i_m_tready | ~r_out_valid;

    // Output register refills from the skid slot first to keep beat order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= i_s_tvalid;
                if (i_s_tvalid) begin
                    r_out_data <= i_s_tdata;
                end
            end
        end else if (i_s_tvalid && o_s_tready) begin
            r_skid_data  <= i_s_tdata;
            r_skid_valid <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/input_stream_reader_trimmer.sv
`default_nettype none
// ============================================================================
// Module   : input_stream_reader_trimmer
// Purpose  : Descriptor-driven trimming FSM. Cuts the host stream to the
//            requested byte count, marks the final beat, drops padding beats
//            and emits an end marker for zero-length transfers.
// Revision : 1.0 - initial release
// ============================================================================
module input_stream_reader_trimmer
    import libstf_stream_pkg::*;
#(
    parameter int N_DATA_BITS = 512,
    parameter int LEN_BITS    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_xfer_valid,
    output logic                     o_xfer_ready,
    input  logic [LEN_BITS-1:0]      i_xfer_bytes,
    input  logic [N_DATA_BITS-1:0]   i_in_tdata,
    input  logic [N_DATA_BITS/8-1:0] i_in_tkeep,
    input  logic                     i_in_tlast,
    input  logic                     i_in_tvalid,
    output logic                     o_in_tready,
    output logic [N_DATA_BITS-1:0]   o_stage_tdata,
    output logic [N_DATA_BITS/8-1:0] o_stage_tkeep,
    output logic                     o_stage_tlast,
    output logic                     o_stage_tvalid,
    input  logic                     i_stage_tready,
    output logic                     o_length_error
);

    localparam int KW = N_DATA_BITS / 8;
    localparam int IW = $clog2(KW) + 1;
    localparam logic [LEN_BITS-1:0] c_BEAT_BYTES = LEN_BITS'(KW);

    reader_state_t           r_state;
    reader_state_t           w_state_next;
    logic [LEN_BITS-1:0]     r_remaining;
    logic [N_DATA_BITS-1:0]  r_stage_tdata;
    logic [KW-1:0]           r_stage_tkeep;
    logic                    r_stage_tlast;
    logic                    r_stage_valid;
    logic                    r_length_error;

    logic                    w_can_load;
    logic                    w_last_chunk;
    logic [KW-1:0]           w_mask;
    logic                    w_load_beat;
    logic                    w_load_zero;
    logic                    w_trim;
    logic                    w_early_last;

    // The stage may take a new beat when it is empty or draining this cycle.
    assign w_can_load   = ~r_stage_valid | i_stage_tready;
    // Compare before subtracting so remaining never underflows.
    assign w_last_chunk = (r_remaining <= c_BEAT_BYTES);

    generate
        if (KW == BYTES_PER_BEAT) begin : g_mask_pkg
            assign w_mask = keep_mask(r_remaining[IW-1:0]);
        end else begin : g_mask_generic
            localparam logic [KW:0] c_ONE = 1;
            logic [KW:0] w_ones;
            assign w_ones = (c_ONE << r_remaining[IW-1:0]) - c_ONE;
            assign w_mask = w_ones[KW-1:0];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake/stage-load controls.
    always_comb begin
        w_state_next = r_state;
        o_xfer_ready = 1'b0;
        o_in_tready  = 1'b0;
        w_load_beat  = 1'b0;
        w_load_zero  = 1'b0;
        w_trim       = 1'b0;
        w_early_last = 1'b0;
        case (r_state)
            IDLE: begin
                o_xfer_ready = 1'b1;
                if (i_xfer_valid) begin
                    w_state_next = (i_xfer_bytes == '0) ? ZERO : STREAM;
                end
            end
            ZERO: begin
                if (w_can_load) begin
                    w_load_zero  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            STREAM: begin
                o_in_tready = w_can_load;
                if (i_in_tvalid && w_can_load) begin
                    w_load_beat = 1'b1;
                    if (w_last_chunk) begin
                        w_trim       = 1'b1;
                        w_state_next = i_in_tlast ? IDLE : DRAIN;
                    end else if (i_in_tlast) begin
                        w_early_last = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                o_in_tready = 1'b1;
                if (i_in_tvalid && i_in_tlast) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Byte counter, staging register and sticky length error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining    <= '0;
            r_stage_valid  <= 1'b0;
            r_stage_tdata  <= '0;
            r_stage_tkeep  <= '0;
            r_stage_tlast  <= 1'b0;
            r_length_error <= 1'b0;
        end else begin
            if (o_xfer_ready && i_xfer_valid) begin
                r_remaining <= i_xfer_bytes;
            end else if (w_load_beat && !w_trim && !w_early_last) begin
                r_remaining <= r_remaining - c_BEAT_BYTES;
            end

            if (w_can_load) begin
                r_stage_valid <= w_load_beat | w_load_zero;
                if (w_load_zero) begin
                    r_stage_tdata <= '0;
                    r_stage_tkeep <= '0;
                    r_stage_tlast <= 1'b1;
                end else if (w_load_beat) begin
                    r_stage_tdata <= i_in_tdata;
                    r_stage_tkeep <= w_trim ? (i_in_tkeep & w_mask) : i_in_tkeep;
                    r_stage_tlast <= w_trim | w_early_last;
                end
            end

            if (w_early_last) begin
                r_length_error <= 1'b1;
            end
        end
    end

    assign o_stage_tdata  = r_stage_tdata;
    assign o_stage_tkeep  = r_stage_tkeep;
    assign o_stage_tlast  = r_stage_tlast;
    assign o_stage_tvalid = r_stage_valid;
    assign o_length_error = r_length_error;

endmodule
`default_nettype wire

// File: rtl/input_stream_reader_data_fifo.sv
`default_nettype none
// ============================================================================
// Module   : input_stream_reader_data_fifo
// Purpose  : Input-side data FIFO: trims the host DMA read stream to the
//            descriptor length and buffers it toward the operator pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module input_stream_reader_data_fifo
    import libstf_stream_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int N_DATA_BITS = 512,
    parameter int LEN_BITS    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     xfer_valid,
    output logic                     xfer_ready,
    input  logic [LEN_BITS-1:0]      xfer_bytes,
    input  logic [N_DATA_BITS-1:0]   input_data_tdata,
    input  logic [N_DATA_BITS/8-1:0] input_data_tkeep,
    input  logic                     input_data_tlast,
    input  logic                     input_data_tvalid,
    output logic                     input_data_tready,
    output logic [N_DATA_BITS-1:0]   output_data_tdata,
    output logic [N_DATA_BITS/8-1:0] output_data_tkeep,
    output logic                     output_data_tlast,
    output logic                     output_data_tvalid,
    input  logic                     output_data_tready,
    output logic [$clog2(DEPTH):0]   filling_level,
    output logic                     length_error
);

    localparam int KW = N_DATA_BITS / 8;
    localparam int PW = N_DATA_BITS + KW + 1;

    logic [N_DATA_BITS-1:0] w_stage_tdata;
    logic [KW-1:0]          w_stage_tkeep;
    logic                   w_stage_tlast;
    logic                   w_stage_tvalid;
    logic                   w_stage_tready;
    logic [PW-1:0]          w_fifo_out;
    logic                   w_fifo_tvalid;
    logic                   w_fifo_tready;
    logic [PW-1:0]          w_dec_out;

    input_stream_reader_trimmer #(
        .N_DATA_BITS (N_DATA_BITS),
        .LEN_BITS    (LEN_BITS)
    ) u_trimmer (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_xfer_valid   (xfer_valid),
        .o_xfer_ready   (xfer_ready),
        .i_xfer_bytes   (xfer_bytes),
        .i_in_tdata     (input_data_tdata),
        .i_in_tkeep     (input_data_tkeep),
        .i_in_tlast     (input_data_tlast),
        .i_in_tvalid    (input_data_tvalid),
        .o_in_tready    (input_data_tready),
        .o_stage_tdata  (w_stage_tdata),
        .o_stage_tkeep  (w_stage_tkeep),
        .o_stage_tlast  (w_stage_tlast),
        .o_stage_tvalid (w_stage_tvalid),
        .i_stage_tready (w_stage_tready),
        .o_length_error (length_error)
    );

    axi_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_s_tdata  ({w_stage_tlast, w_stage_tkeep, w_stage_tdata}),
        .i_s_tvalid (w_stage_tvalid),
        .o_s_tready (w_stage_tready),
        .o_m_tdata  (w_fifo_out),
        .o_m_tvalid (w_fifo_tvalid),
        .i_m_tready (w_fifo_tready),
        .o_count    (filling_level)
    );

    axi_ready_de_coupler #(
        .WIDTH (PW)
    ) u_decoupler (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_s_tdata  (w_fifo_out),
        .i_s_tvalid (w_fifo_tvalid),
        .o_s_tready (w_fifo_tready),
        .o_m_tdata  (w_dec_out),
        .o_m_tvalid (output_data_tvalid),
        .i_m_tready (output_data_tready)
    );

    assign output_data_tdata = w_dec_out[N_DATA_BITS-1:0];
    assign output_data_tkeep = w_dec_out[N_DATA_BITS +: KW];
    assign output_data_tlast = w_dec_out[PW-1];

endmodule
`default_nettype wire

// File: tb/tb_input_stream_reader_data_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_input_stream_reader_data_fifo
// Purpose  : Self-checking bench with a transfer-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_stream_reader_data_fifo;

    localparam int DEPTH = 16;
    localparam int NB    = 512;
    localparam int KW    = NB / 8;
    localparam int LB    = 32;
    localparam int FW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          xfer_valid;
    logic          xfer_ready;
    logic [LB-1:0] xfer_bytes;
    logic [NB-1:0] input_data_tdata;
    logic [KW-1:0] input_data_tkeep;
    logic          input_data_tlast;
    logic          input_data_tvalid;
    logic          input_data_tready;
    logic [NB-1:0] output_data_tdata;
    logic [KW-1:0] output_data_tkeep;
    logic          output_data_tlast;
    logic          output_data_tvalid;
    logic          output_data_tready;
    logic [FW-1:0] filling_level;
    logic          length_error;

    input_stream_reader_data_fifo #(
        .DEPTH       (DEPTH),
        .N_DATA_BITS (NB),
        .LEN_BITS    (LB)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .xfer_valid         (xfer_valid),
        .xfer_ready         (xfer_ready),
        .xfer_bytes         (xfer_bytes),
        .input_data_tdata   (input_data_tdata),
        .input_data_tkeep   (input_data_tkeep),
        .input_data_tlast   (input_data_tlast),
        .input_data_tvalid  (input_data_tvalid),
        .input_data_tready  (input_data_tready),
        .output_data_tdata  (output_data_tdata),
        .output_data_tkeep  (output_data_tkeep),
        .output_data_tlast  (output_data_tlast),
        .output_data_tvalid (output_data_tvalid),
        .output_data_tready (output_data_tready),
        .filling_level      (filling_level),
        .length_error       (length_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    beat_t host_q[$];
    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    model_err = 1'b0;
    bit    rand_rdy  = 1'b0;
    bit    host_done = 1'b1;
    bit    watch_tready = 1'b0;
    bit    saw_tready   = 1'b0;

    task automatic check_val(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [KW-1:0] low_ones(input int k);
        logic [KW-1:0] m;
        for (int j = 0; j < KW; j++) m[j] = (j < k);
        return m;
    endfunction

    // Host beats for one transfer: full keep, tlast on the final beat.
    task automatic make_host(input int n, input bit rand_last_keep);
        beat_t b;
        host_q.delete();
        for (int i = 0; i < n; i++) begin
            for (int w = 0; w < NB / 32; w++) b.data[w*32 +: 32] = $urandom();
            b.keep = '1;
            if (rand_last_keep && i == n - 1) b.keep = {$urandom(), $urandom()} | 64'h1;
            b.last = (i == n - 1);
            host_q.push_back(b);
        end
    endtask

    // Transfer-level expectation: the beat holding byte L-1 ends the output;
    // an earlier host tlast ends it with an error; later beats are dropped.
    task automatic model(input int len);
        beat_t b;
        int    nb;
        nb = (len + KW - 1) / KW;
        if (len == 0) begin
            b.data = '0; b.keep = '0; b.last = 1'b1;
            exp_q.push_back(b);
            return;
        end
        for (int i = 0; i < host_q.size(); i++) begin
            b = host_q[i];
            if (i == nb - 1) begin
                b.keep = b.keep & low_ones(len - KW * (nb - 1));
                b.last = 1'b1;
                exp_q.push_back(b);
                break;
            end else if (b.last) begin
                model_err = 1'b1;
                exp_q.push_back(b);
                break;
            end else begin
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic send_desc(input int len);
        bit ok;
        ok = 1'b0;
        xfer_bytes = LB'(len);
        xfer_valid = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (xfer_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        xfer_valid = 1'b0;
        check_val("desc_accept", NB'(ok), NB'(1));
    endtask

    task automatic send_host(input int pause_at);
        bit ok;
        host_done = 1'b0;
        for (int i = 0; i < host_q.size(); i++) begin
            if (i == pause_at) begin
                repeat (12) @(posedge clk);
                #1;
                check_val("xfer_ready_in_drain", NB'(xfer_ready), NB'(0));
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            input_data_tdata  = host_q[i].data;
            input_data_tkeep  = host_q[i].keep;
            input_data_tlast  = host_q[i].last;
            input_data_tvalid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 3000; t++) begin
                @(negedge clk);
                if (input_data_tready) begin ok = 1'b1; break; end
            end
            @(posedge clk); #1;
            input_data_tvalid = 1'b0;
            check_val("host_accept", NB'(ok), NB'(1));
            if (!ok) break;
        end
        host_done = 1'b1;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && host_done) break;
        end
        check_val("drain_done", NB'(exp_q.size()), NB'(0));
        @(posedge clk); #1;
    endtask

    task automatic run_xfer(input int len, input int n, input int pause_at, input bit rand_keep);
        make_host(n, rand_keep);
        model(len);
        fork
            send_desc(len);
            send_host(pause_at);
        join
        wait_drain();
        @(negedge clk);
        check_val("xfer_ready_idle", NB'(xfer_ready), NB'(1));
        check_val("length_error", NB'(length_error), NB'(model_err));
        @(posedge clk); #1;
    endtask

    // Output scoreboard.
    always @(negedge clk) begin : mon
        beat_t e;
        if (rst_n && output_data_tvalid && output_data_tready) begin
            check_val("beat_expected", NB'(exp_q.size() != 0), NB'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_val("tdata", output_data_tdata, e.data);
                check_val("tkeep", NB'(output_data_tkeep), NB'(e.keep));
                check_val("tlast", NB'(output_data_tlast), NB'(e.last));
            end
        end
    end

    always @(negedge clk) begin
        if (watch_tready && input_data_tready) saw_tready <= 1'b1;
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) output_data_tready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int  len;
        int  nb;
        int  n;
        int  mode;
        bit  reached;
        rst_n = 1'b0;
        xfer_valid = 1'b0;
        xfer_bytes = '0;
        input_data_tdata = '0;
        input_data_tkeep = '0;
        input_data_tlast = 1'b0;
        input_data_tvalid = 1'b0;
        output_data_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_xfer_ready", NB'(xfer_ready), NB'(1));
        check_val("rst_in_tready", NB'(input_data_tready), NB'(0));
        check_val("rst_out_tvalid", NB'(output_data_tvalid), NB'(0));
        check_val("rst_fill", NB'(filling_level), NB'(0));
        check_val("rst_len_err", NB'(length_error), NB'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Trim 200 bytes out of four full beats.
        run_xfer(200, 4, -1, 1'b0);
        // Exact two beats; third host beat is padding.
        run_xfer(128, 3, 2, 1'b0);
        // Zero-length descriptor: only an end marker, no input consumed.
        saw_tready = 1'b0;
        watch_tready = 1'b1;
        run_xfer(0, 0, -1, 1'b0);
        watch_tready = 1'b0;
        check_val("zero_no_tready", NB'(saw_tready), NB'(0));

        // Randomized transfers under random output backpressure.
        rand_rdy = 1'b1;
        for (int k = 0; k < 14; k++) begin
            len  = $urandom_range(0, 600);
            if (k % 4 == 0) len = KW * $urandom_range(1, 5);
            nb   = (len + KW - 1) / KW;
            mode = $urandom_range(0, 3);
            if (len == 0)                 n = 0;
            else if (mode == 0)           n = nb + $urandom_range(1, 2);
            else if (mode == 3 && nb > 1) n = $urandom_range(1, nb - 1);
            else                          n = nb;
            run_xfer(len, n, -1, 1'b1);
        end
        rand_rdy = 1'b0;
        output_data_tready = 1'b1;

        // Host tlast on beat 2 of a 300-byte transfer; error is sticky.
        run_xfer(300, 2, -1, 1'b0);
        run_xfer(64, 1, -1, 1'b0);

        // Fill the FIFO completely with the output stalled.
        output_data_tready = 1'b0;
        make_host(DEPTH + 4, 1'b0);
        model(KW * (DEPTH + 4));
        send_desc(KW * (DEPTH + 4));
        fork
            send_host(-1);
        join_none
        reached = 1'b0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (filling_level == FW'(DEPTH)) begin reached = 1'b1; break; end
        end
        check_val("fill_reached", NB'(reached), NB'(1));
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_val("full_in_tready", NB'(input_data_tready), NB'(0));
        check_val("full_level", NB'(filling_level), NB'(DEPTH));
        @(posedge clk); #1;
        output_data_tready = 1'b1;
        wait_drain();
        @(negedge clk);
        check_val("fill_xfer_ready", NB'(xfer_ready), NB'(1));
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a transfer.
        output_data_tready = 1'b0;
        send_desc(500);
        input_data_tdata  = {16{32'hA5A5_0001}};
        input_data_tkeep  = '1;
        input_data_tlast  = 1'b0;
        input_data_tvalid = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_xfer_ready", NB'(xfer_ready), NB'(1));
        check_val("mid_rst_in_tready", NB'(input_data_tready), NB'(0));
        check_val("mid_rst_out_tvalid", NB'(output_data_tvalid), NB'(0));
        check_val("mid_rst_fill", NB'(filling_level), NB'(0));
        check_val("mid_rst_len_err", NB'(length_error), NB'(0));
        input_data_tvalid = 1'b0;
        exp_q.delete();
        model_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        output_data_tready = 1'b1;
        @(posedge clk); #1;
        run_xfer(64, 1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
